// File: rtl/bl_zone_dimmer_pkg.sv
// Shared types and constants for the backlight zone dimmer.
package bl_pkg;

  localparam int unsigned DUTY_W     = 8;
  localparam int unsigned PWM_PERIOD = 255;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FILTER  = 2'd2
  } state_e;

endpackage

// File: rtl/bl_zone_dimmer_if.sv
// Zone-side signal bundle: frame window, zone value, controls and LED outputs.
interface bl_zone_dimmer_if;
  import bl_pkg::*;

  logic  iV_Duty;
  duty_t iBlockData;
  logic  iEnable;
  logic  iBypass;
  logic  oPWM;
  duty_t oDuty;
  logic  oUpdate;

  modport master (
    output iV_Duty, iBlockData, iEnable, iBypass,
    input  oPWM, oDuty, oUpdate
  );

  modport slave (
    input  iV_Duty, iBlockData, iEnable, iBypass,
    output oPWM, oDuty, oUpdate
  );
endinterface

// File: rtl/bl_zone_dimmer_pwm.sv
// Prescaled 255-tick PWM with a period-aligned duty double-buffer.
module bl_pwm_gen
  import bl_pkg::*;
#(
  parameter int unsigned PRESCALE  = 16,
  parameter duty_t       INIT_DUTY = 8'd255
) (
  input  logic  iODCK,
  input  logic  iRST,
  input  logic  enable_i,
  input  duty_t duty_shadow_i,
  output logic  pwm_o
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX  = PS_W'(PRESCALE - 1);
  localparam duty_t           CNT_MAX = DUTY_W'(PWM_PERIOD - 1);

  logic [PS_W-1:0] prescale_cnt_q, prescale_cnt_d;
  duty_t           pwm_cnt_q, pwm_cnt_d;
  duty_t           duty_active_q, duty_active_d;
  logic            pwm_q, pwm_d;
  logic            tick_c;

  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      prescale_cnt_q <= '0;
      pwm_cnt_q      <= '0;
      duty_active_q  <= INIT_DUTY;
      pwm_q          <= 1'b0;
    end else begin
      prescale_cnt_q <= prescale_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_active_q  <= duty_active_d;
      pwm_q          <= pwm_d;
    end
  end

  // Shadow is only adopted at the last tick of a period, or freely while disabled.
  always_comb begin
    prescale_cnt_d = prescale_cnt_q;
    pwm_cnt_d      = pwm_cnt_q;
    duty_active_d  = duty_active_q;
    pwm_d          = 1'b0;
    tick_c         = (prescale_cnt_q == PS_MAX);
    if (!enable_i) begin
      prescale_cnt_d = '0;
      pwm_cnt_d      = '0;
      duty_active_d  = duty_shadow_i;
    end else begin
      prescale_cnt_d = tick_c ? '0 : prescale_cnt_q + PS_W'(1);
      if (tick_c) begin
        if (pwm_cnt_q == CNT_MAX) begin
          pwm_cnt_d     = '0;
          duty_active_d = duty_shadow_i;
        end else begin
          pwm_cnt_d = pwm_cnt_q + DUTY_W'(1);
        end
      end
      pwm_d = (pwm_cnt_q < duty_active_q);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/bl_zone_dimmer.sv
// Per-zone dimmer: frame-edge capture, IIR smoothing with min clamp, and PWM drive.
module bl_zone_dimmer
  import bl_pkg::*;
#(
  parameter int unsigned PRESCALE     = 16,
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter duty_t       MIN_DUTY     = 8'd16,
  parameter duty_t       INIT_DUTY    = 8'd255
) (
  input logic              iODCK,
  input logic              iRST,
  bl_zone_dimmer_if.slave  zif
);

  state_e            state_q, state_d;
  logic              v_dly_q;
  duty_t             target_q, target_d;
  logic signed [8:0] step_q, step_d;
  duty_t             duty_shadow_q, duty_shadow_d;
  logic              update_q, update_d;

  logic              fall_c;
  logic signed [8:0] diff_c, shr_c, step_c;
  logic signed [9:0] sum_c;
  duty_t             clamp_c;

  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      state_q       <= IDLE;
      v_dly_q       <= 1'b0;
      target_q      <= '0;
      step_q        <= '0;
      duty_shadow_q <= INIT_DUTY;
      update_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      v_dly_q       <= zif.iV_Duty;
      target_q      <= target_d;
      step_q        <= step_d;
      duty_shadow_q <= duty_shadow_d;
      update_q      <= update_d;
    end
  end

  // Filter datapath; a nonzero error always moves the duty by at least one LSB.
  always_comb begin
    fall_c = v_dly_q & ~zif.iV_Duty;
    diff_c = $signed({1'b0, target_q}) - $signed({1'b0, duty_shadow_q});
    shr_c  = diff_c >>> SMOOTH_SHIFT;
    step_c = (zif.iBypass || (SMOOTH_SHIFT == 0)) ? diff_c : shr_c;
    if ((step_c == 9'sd0) && (diff_c != 9'sd0)) begin
      step_c = diff_c[8] ? -9'sd1 : 9'sd1;
    end
    sum_c = $signed({2'b00, duty_shadow_q}) + $signed({step_q[8], step_q});
    if (sum_c < $signed({2'b00, MIN_DUTY})) begin
      clamp_c = MIN_DUTY;
    end else if (sum_c > 10'sd255) begin
      clamp_c = 8'hFF;
    end else begin
      clamp_c = sum_c[7:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    step_d        = step_q;
    duty_shadow_d = duty_shadow_q;
    update_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall_c) begin
          target_d = zif.iBlockData;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        step_d  = step_c;
        state_d = FILTER;
      end
      FILTER: begin
        duty_shadow_d = clamp_c;
        update_d      = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  bl_pwm_gen #(
    .PRESCALE  (PRESCALE),
    .INIT_DUTY (INIT_DUTY)
  ) u_pwm (
    .iODCK         (iODCK),
    .iRST          (iRST),
    .enable_i      (zif.iEnable),
    .duty_shadow_i (duty_shadow_q),
    .pwm_o         (zif.oPWM)
  );

  assign zif.oDuty   = duty_shadow_q;
  assign zif.oUpdate = update_q;

endmodule

// File: tb/tb_bl_zone_dimmer.sv
// Self-checking bench for bl_zone_dimmer: timeline model plus directed frames.
module tb_bl_zone_dimmer;

  localparam int unsigned PRESC = 4;
  localparam int unsigned SHIFT = 2;
  localparam int          MIN_D = 16;
  localparam int          INIT_D = 255;
  localparam int          DIV   = 1 << SHIFT;
  localparam int          PER_CYC = 255 * PRESC;

  logic clk;
  logic rst_n;
  bl_zone_dimmer_if zif();

  bl_zone_dimmer #(
    .PRESCALE     (PRESC),
    .SMOOTH_SHIFT (SHIFT),
    .MIN_DUTY     (8'(MIN_D)),
    .INIT_DUTY    (8'(INIT_D))
  ) dut (
    .iODCK (clk),
    .iRST  (rst_n),
    .zif   (zif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  int cyc = 0;
  int hi_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected filter result from the smoothing rules, using integer floor division.
  function automatic int filt(input int old, input int tgt, input bit byp);
    int diff, step, r;
    diff = tgt - old;
    if (byp) step = diff;
    else begin
      step = (diff >= 0) ? diff / DIV : -((-diff + DIV - 1) / DIV);
      if (step == 0 && diff != 0) step = (diff > 0) ? 1 : -1;
    end
    r = old + step;
    if (r < MIN_D) r = MIN_D;
    if (r > 255) r = 255;
    return r;
  endfunction

  // Timeline model: frame capture timestamps and PWM position from enabled-cycle count.
  int m_cyc, m_fall, m_target, m_next, m_shadow, m_active, m_n;
  bit m_vprev, m_upd, m_pwm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_fall <= -10; m_target <= 0; m_next <= INIT_D;
      m_shadow <= INIT_D; m_active <= INIT_D; m_n <= 0;
      m_vprev <= 1'b0; m_upd <= 1'b0; m_pwm <= 1'b0;
    end else begin
      m_cyc   <= m_cyc + 1;
      m_vprev <= zif.iV_Duty;
      if (m_vprev && !zif.iV_Duty && (m_cyc > m_fall + 2)) begin
        m_fall   <= m_cyc;
        m_target <= int'(zif.iBlockData);
      end
      if (m_cyc == m_fall + 1) m_next <= filt(m_shadow, m_target, zif.iBypass);
      if (m_cyc == m_fall + 2) begin
        m_shadow <= m_next;
        m_upd    <= 1'b1;
      end else begin
        m_upd <= 1'b0;
      end
      if (zif.iEnable) begin
        m_pwm <= (((m_n / PRESC) % 255) < m_active);
        if ((m_n % PER_CYC) == PER_CYC - 1) m_active <= m_shadow;
        m_n <= m_n + 1;
      end else begin
        m_pwm    <= 1'b0;
        m_n      <= 0;
        m_active <= m_shadow;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (zif.oPWM === 1'b1) hi_cnt <= hi_cnt + 1;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_duty", 32'(zif.oDuty), 32'(m_shadow));
      chk("model_update", 32'(zif.oUpdate), 32'(m_upd));
      chk("model_pwm", 32'(zif.oPWM), 32'(m_pwm));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(posedge clk);
    #2;
  endtask

  // One frame: raise window, drop it with the zone value, watch the update pulse.
  task automatic frame(input logic [7:0] val, input bit drop, output int duty_o);
    int npulse, first_idx;
    npulse = 0; first_idx = 0;
    zif.iV_Duty = 1'b1;
    wait_cycles(2);
    zif.iV_Duty = 1'b0;
    zif.iBlockData = val;
    @(posedge clk);
    #2;
    if (drop) zif.iV_Duty = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (zif.oUpdate === 1'b1) begin
        npulse++;
        if (first_idx == 0) first_idx = i;
      end
      if (drop && i == 2) zif.iV_Duty = 1'b0;
    end
    @(posedge clk);
    #2;
    chk("upd_latency", 32'(first_idx), 32'd3);
    chk("upd_count", 32'(npulse), 32'd1);
    duty_o = int'(zif.oDuty);
  endtask

  initial begin
    int d, prev, h0, h1, h2, h3, start;
    rst_n = 1'b0;
    zif.iV_Duty = 1'b0; zif.iBlockData = 8'd0; zif.iEnable = 1'b1; zif.iBypass = 1'b0;
    #1 chk_on = 1'b1;
    wait_cycles(3);
    chk("rst_duty", 32'(zif.oDuty), 32'd255);
    chk("rst_pwm", 32'(zif.oPWM), 32'd0);
    chk("rst_update", 32'(zif.oUpdate), 32'd0);
    rst_n = 1'b1;
    wait_cycles(1);
    h0 = hi_cnt;
    wait_cycles(20);
    chk("full_duty_pwm_high", 32'(hi_cnt - h0), 32'd20);

    frame(8'd100, 1'b0, d);
    chk("smooth_first", 32'(d), 32'd216);
    prev = d;
    for (int f = 0; f < 40 && d != 100; f++) begin
      frame(8'd100, 1'b0, d);
      if (prev == 101) chk("conv_101_to_100", 32'(d), 32'd100);
      prev = d;
    end
    chk("smooth_converged", 32'(d), 32'd100);
    frame(8'd103, 1'b0, d);
    chk("small_up_step", 32'(d), 32'd101);

    zif.iBypass = 1'b1;
    frame(8'd5, 1'b0, d);
    chk("bypass_clamp_min", 32'(d), 32'd16);
    frame(8'd255, 1'b0, d);
    chk("bypass_max", 32'(d), 32'd255);
    frame(8'd64, 1'b0, d);
    chk("bypass_64", 32'(d), 32'd64);

    zif.iEnable = 1'b0;
    wait_cycles(5);
    zif.iEnable = 1'b1;
    start = cyc;
    h0 = hi_cnt;
    wait_until(start + PER_CYC);
    h1 = hi_cnt;
    chk("pwm_period1_high", 32'(h1 - h0), 32'd256);
    wait_until(start + PER_CYC + 300);
    frame(8'd128, 1'b0, d);
    chk("midperiod_shadow", 32'(d), 32'd128);
    wait_until(start + 2 * PER_CYC);
    h2 = hi_cnt;
    chk("pwm_period2_high", 32'(h2 - h1), 32'd256);
    wait_until(start + 3 * PER_CYC);
    h3 = hi_cnt;
    chk("pwm_period3_high", 32'(h3 - h2), 32'd512);

    zif.iBypass = 1'b0;
    frame(8'd200, 1'b1, d);
    chk("dropped_fall_value", 32'(d), 32'd146);

    zif.iEnable = 1'b0;
    wait_cycles(2);
    h0 = hi_cnt;
    zif.iBypass = 1'b1;
    frame(8'd200, 1'b0, d);
    chk("disabled_bypass_200", 32'(d), 32'd200);
    zif.iBypass = 1'b0;
    frame(8'd40, 1'b0, d);
    chk("disabled_smooth_160", 32'(d), 32'd160);
    chk("disabled_pwm_low", 32'(hi_cnt - h0), 32'd0);

    zif.iEnable = 1'b1;
    wait_cycles(3);
    chk("pre_reset_pwm", 32'(zif.oPWM), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_duty", 32'(zif.oDuty), 32'd255);
    chk("midrun_rst_pwm", 32'(zif.oPWM), 32'd0);
    chk("midrun_rst_update", 32'(zif.oUpdate), 32'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(10);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
